sram_responder: RTL and testbench

//  Cycle-accurate, synthesizable model of the external 16-bit asynchronous SRAM chip:
//  the device end of the SRAM_* pin interface driven by the team's SRAM controller.

---
 rtl/sram_responder.sv | 151 +++++++++++++++
 tb/tb_sram_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: device-side model of the 16-bit asynchronous SRAM chip.
// It stores halfwords with byte-lane control and can add read latency.
// After every reset it sweeps CLEAR_VALUE through memory while busy is high.
// It counts accepted writes and the read cycles it serves.
//
// SRAM_DQ handshake: the chip never drives DQ unless a read is requested
// (CE_N=0, OE_N=0, WE_N=1).
// During a read, each enabled lane carries data and each disabled lane floats.
// A "not ready" read drives 16'h0000 on the enabled lanes.
// A write is sampled on the rising clk edge while CE_N=0 and WE_N=0.
module sram_responder #(
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter int unsigned READ_LATENCY = 0,
    parameter logic [15:0] CLEAR_VALUE  = 16'h0
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] SRAM_DQ,
    input  logic [17:0] SRAM_ADDR,
    input  logic        SRAM_UB_N,
    input  logic        SRAM_LB_N,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    output logic        busy,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] ptr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [15:0]           mem [DEPTH];
    logic                  wr;
    logic                  rd;
    logic                  wr_lane;
    logic                  pipe_ready;
    logic [15:0]           rd_data;
    logic                  unused_addr_hi;

    // Upper address bits alias onto the implemented depth.
    assign idx            = SRAM_ADDR[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^SRAM_ADDR[17:DEPTH_LOG2];

    // A low WE_N wins over OE_N, so wr and rd are never both high.
    assign wr      = !SRAM_CE_N && !SRAM_WE_N;
    assign rd      = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign wr_lane = !SRAM_UB_N || !SRAM_LB_N;

    // Control FSM: the clear sweep after reset, the run state, and the access counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            ptr      <= '0;
            busy     <= 1'b1;
            wr_count <= 16'h0000;
            rd_count <= 16'h0000;
        end else begin
            if (rd) begin
                rd_count <= rd_count + 16'd1;
            end
            case (state)
                S_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (wr && wr_lane) begin
                        wr_count <= wr_count + 16'd1;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage: the sweep owns the array during CLEAR, and pin writes land per byte lane in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[ptr] <= CLEAR_VALUE;
            end else if (wr) begin
                if (!SRAM_LB_N) begin
                    mem[idx][7:0] <= SRAM_DQ[7:0];
                end
                if (!SRAM_UB_N) begin
                    mem[idx][15:8] <= SRAM_DQ[15:8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY > 0) begin : g_pipe
            logic [READ_LATENCY-1:0] rd_pipe;
            logic [DEPTH_LOG2-1:0]   idx_pipe [READ_LATENCY];
            logic                    match;

            // Latency pipeline: shift {rd, idx} one stage per clk. Reset flushes only the rd flags.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_pipe <= '0;
                end else begin
                    rd_pipe[0] <= rd;
                    for (int k = 1; k < int'(READ_LATENCY); k++) begin
                        rd_pipe[k] <= rd_pipe[k-1];
                    end
                end
                idx_pipe[0] <= idx;
                for (int k = 1; k < int'(READ_LATENCY); k++) begin
                    idx_pipe[k] <= idx_pipe[k-1];
                end
            end

            // Data is ready only after the same address has been read for the full latency.
            always_comb begin
                match = &rd_pipe;
                for (int k = 0; k < int'(READ_LATENCY); k++) begin
                    if (idx_pipe[k] != idx) begin
                        match = 1'b0;
                    end
                end
            end

            assign pipe_ready = match;
        end else begin : g_nopipe
            assign pipe_ready = 1'b1;
        end
    endgenerate

    // Read data comes straight from the array.
    // A write to the read location therefore shows on the next read cycle.
    assign rd_data = (busy || !pipe_ready) ? 16'h0000 : mem[idx];

    assign SRAM_DQ[15:8] = (rd && !SRAM_UB_N) ? rd_data[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (rd && !SRAM_LB_N) ? rd_data[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: drives two sram_responder instances from the same pins.
// One instance has zero read latency and the other has two cycles.
// Both are checked against a memory and a read-stability model held in the bench.
// Each DQ net has pullups, so a floating lane reads back as all ones.
module tb_sram_responder;

  localparam int DL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic        drv_en;
  logic [15:0] drv_val;
  wire  [15:0] dq0, dq2;
  logic        busy0, busy2;
  logic [15:0] wc0, rc0, wc2, rc2;

  assign dq0 = drv_en ? drv_val : 16'hzzzz;
  assign dq2 = drv_en ? drv_val : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pull
    pullup pu0 (dq0[g]);
    pullup pu2 (dq2[g]);
  end

  sram_responder #(.DEPTH_LOG2(DL), .READ_LATENCY(0), .CLEAR_VALUE(16'h0)) u_l0 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq0), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .busy(busy0), .wr_count(wc0), .rd_count(rc0)
  );

  sram_responder #(.DEPTH_LOG2(DL), .READ_LATENCY(2), .CLEAR_VALUE(16'h0)) u_l2 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .busy(busy2), .wr_count(wc2), .rd_count(rc2)
  );

  // Reference model: halfword array, access totals, and read stability.
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mem_m [16];
  int          wr_m = 0;
  int          rd_m = 0;
  bit          sweeping = 1'b1;
  int          run_len = 0;
  logic [3:0]  run_idx = 4'h0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pin_view(input logic [15:0] v, input logic ub, input logic lb);
    logic [15:0] r;
    r[15:8] = ub ? 8'hFF : v[15:8];
    r[7:0]  = lb ? 8'hFF : v[7:0];
    return r;
  endfunction

  task automatic go_idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0; drv_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    go_idle();
    step();
    run_len = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0;
    wr_m = 0;
    rd_m = 0;
    run_len = 0;
    sweeping = 1'b1;
  endtask

  // Counts the remaining negedges with busy high, up to a 40-cycle bound.
  task automatic count_busy(input string tag, input int exp_n);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy0) break;
      n++;
      step();
    end
    check(tag, 16'(n), 16'(exp_n));
    check({tag, "_l2_idle"}, {15'b0, busy2}, 16'h0);
    step();
    sweeping = 1'b0;
    run_len = 0;
  endtask

  task automatic wr_op(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
    addr = a; drv_val = d; drv_en = 1'b1;
    ub_n = ub; lb_n = lb; ce_n = 1'b0; we_n = 1'b0;
    oe_n = 1'($urandom_range(0, 1));
    step();
    if (!lb) mem_m[a[3:0]][7:0]  = d[7:0];
    if (!ub) mem_m[a[3:0]][15:8] = d[15:8];
    if (!ub || !lb) wr_m++;
    run_len = 0;
    go_idle();
  endtask

  task automatic rd_op(input logic [17:0] a, input logic ub, input logic lb, input string tag);
    logic [3:0]  i;
    logic        ready;
    logic [15:0] v0, v2;
    i = a[3:0];
    ready = (run_len >= 2) && (run_idx == i);
    v0 = sweeping ? 16'h0 : mem_m[i];
    v2 = (sweeping || !ready) ? 16'h0 : mem_m[i];
    exp_q.push_back(pin_view(v0, ub, lb));
    exp_q.push_back(pin_view(v2, ub, lb));
    addr = a; ub_n = ub; lb_n = lb; drv_en = 1'b0;
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    @(negedge clk);
    check({tag, "_l0"}, dq0, exp_q.pop_front());
    check({tag, "_l2"}, dq2, exp_q.pop_front());
    step();
    rd_m++;
    if (run_len > 0 && run_idx == i) run_len++;
    else begin
      run_idx = i;
      run_len = 1;
    end
    go_idle();
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, "_wc0"}, wc0, 16'(wr_m));
    check({tag, "_rc0"}, rc0, 16'(rd_m));
    check({tag, "_wc2"}, wc2, 16'(wr_m));
    check({tag, "_rc2"}, rc2, 16'(rd_m));
    step();
  endtask

  initial begin
    go_idle();
    addr = 18'h0; drv_val = 16'h0; rst = 1'b1;
    clear_model();

    // 1: one-clock reset, a 16-clock sweep, then all locations read as zero
    step();
    rst = 1'b0;
    count_busy("t1_sweep_len", 16);
    check_counts("t1_reset");
    for (int i = 0; i < 16; i++) rd_op(18'(i), 1'b0, 1'b0, "t1_clear");

    // 2: full-word writes, then a zero-latency readback
    wr_op(18'h4, 16'h5678, 1'b0, 1'b0);
    wr_op(18'h5, 16'h1234, 1'b0, 1'b0);
    rd_op(18'h4, 1'b0, 1'b0, "t2_rd4");
    rd_op(18'h5, 1'b0, 1'b0, "t2_rd5");
    check_counts("t2");

    // 3: lower-lane write only, then a read with the lower lane disabled
    wr_op(18'h5, 16'hAABB, 1'b1, 1'b0);
    rd_op(18'h5, 1'b0, 1'b0, "t3_merge");
    rd_op(18'h5, 1'b0, 1'b1, "t3_lb_float");

    // 4: a held read waits out the latency, and an address change restarts the wait
    idle_step();
    for (int k = 0; k < 3; k++) rd_op(18'h5, 1'b0, 1'b0, "t4_hold5");
    for (int k = 0; k < 3; k++) rd_op(18'h4, 1'b0, 1'b0, "t4_hold4");
    idle_step();
    for (int k = 0; k < 3; k++) rd_op(18'h5, 1'b0, 1'b0, "t4_again5");
    @(negedge clk);
    check("t4_after_l2", dq2, 16'hFFFF);
    step();

    // 5: upper address bits alias onto the implemented depth
    wr_op(18'h13, 16'hCAFE, 1'b0, 1'b0);
    rd_op(18'h3, 1'b0, 1'b0, "t5_alias");

    // 6: reset during a write and during a read; access while clearing; sweep restart
    addr = 18'h2; drv_val = 16'h7777; drv_en = 1'b1;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; rst = 1'b1;
    step();
    go_idle();
    addr = 18'h4; ce_n = 1'b0; oe_n = 1'b0;
    step();
    rst = 1'b0;
    go_idle();
    clear_model();
    @(negedge clk);
    check("t6_dq_float_l0", dq0, 16'hFFFF);
    check("t6_dq_float_l2", dq2, 16'hFFFF);
    check("t6_busy", {15'b0, busy0}, 16'h1);
    check("t6_wc", wc0, 16'h0);
    check("t6_rc", rc0, 16'h0);
    step();
    addr = 18'h0; drv_val = 16'h7777; drv_en = 1'b1;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    step();
    run_len = 0;
    go_idle();
    rd_op(18'h4, 1'b0, 1'b0, "t6_rd_busy");
    for (int k = 0; k < 4; k++) idle_step();
    check_counts("t6_mid_sweep");
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
    count_busy("t6_restart_len", 16);
    rd_op(18'h0, 1'b0, 1'b0, "t6_discard");
    check_counts("t6_post");

    // 7: random back-to-back writes and reads, checked through the expected queue
    for (int i = 0; i < 16; i++) wr_op(18'(i), 16'($urandom), 1'b0, 1'b0);
    for (int n = 0; n < 120; n++) begin
      int          op;
      logic [17:0] a;
      logic        ub, lb;
      op = $urandom_range(0, 2);
      a  = {14'($urandom), 4'($urandom_range(0, 3))};
      ub = ($urandom_range(0, 3) == 0);
      lb = ($urandom_range(0, 3) == 0);
      case (op)
        0: wr_op(a, 16'($urandom), ub, lb);
        1: rd_op(a, ub, lb, "t7_rd");
        default: for (int k = 0; k < 3; k++) rd_op(a, ub, lb, "t7_hold");
      endcase
    end
    check_counts("t7_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
